// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART transmit path
package uart_pkg;

   localparam logic [1:0] PAR_NONE     = 2'b00;
   localparam logic [1:0] PAR_ODD      = 2'b01;
   localparam logic [1:0] PAR_EVEN     = 2'b10;
   localparam logic [1:0] PAR_NONE_ALT = 2'b11;

   localparam logic STOP_ONE = 1'b0;
   localparam logic STOP_TWO = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } state_t;

   // Only the two real parity modes put a parity bit on the line.
   function automatic logic has_parity(input logic [1:0] ptype);
      return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
   endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serializer: start, LSB-first data, optional parity, 1/2 stop bits
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   input  logic                  send,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  parity_in,
   input  logic [1:0]            parity_type,
   input  logic                  stop_bits,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   state_t                state;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_next;
   logic                  par_q;
   logic [1:0]            ptype_q;
   logic                  stop_q;
   logic                  stop_cnt;

   always_comb begin
      shreg_next = shreg >> 1;
   end

   // Every bit state only advances on baud_tick, so each level is held one full baud period.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         tx_out   <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_q    <= 1'b0;
         ptype_q  <= PAR_NONE;
         stop_q   <= STOP_ONE;
         stop_cnt <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx_out <= 1'b1;
               if (send) begin
                  shreg    <= data_in;
                  par_q    <= parity_in;
                  ptype_q  <= parity_type;
                  stop_q   <= stop_bits;
                  bit_cnt  <= '0;
                  stop_cnt <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (baud_tick) begin
                  tx_out <= 1'b0;
                  state  <= ST_START;
               end
            end
            ST_START: begin
               if (baud_tick) begin
                  bit_cnt <= '0;
                  tx_out  <= shreg[0];
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (baud_tick) begin
                  shreg <= shreg_next;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     if (has_parity(ptype_q)) begin
                        tx_out <= par_q;
                        state  <= ST_PARITY;
                     end else begin
                        tx_out   <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx_out  <= shreg_next[0];
                  end
               end
            end
            ST_PARITY: begin
               if (baud_tick) begin
                  tx_out   <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (baud_tick) begin
                  if ((stop_q == STOP_TWO) && !stop_cnt) begin
                     stop_cnt <= 1'b1;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               tx_out <= 1'b1;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Transmit-side frame serializer for the UART transmitter. It accepts one data byte per request, together with the parity bit produced by the parity generator and the parity mode. It then drives the serial line with start bit, data bits (LSB first), an optional parity bit and one or two stop bits, one bit per baud period. The block sits between the parity generator / host interface and the TX pin; bit timing comes from an external baud tick.

## Interface

- `DATA_WIDTH`, default 8, number of data bits per frame.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `baud_tick`  in  1  one-cycle pulse marking each baud period boundary.
- `send`  in  1  transmit request; accepted when `busy`=0.
- `data_in`  in  DATA_WIDTH  byte to transmit.
- `parity_in`  in  1  parity bit from the parity generator for `data_in`.
- `parity_type`  in  2  00 none, 01 odd, 10 even, 11 none.
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx_out`  out  1  serial line; idle high.
- `busy`  out  1  high from acceptance through the end of the last stop bit.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation

- States: IDLE, ARMED, START, DATA, PARITY, STOP.
- **Reset values:** state IDLE, `tx_out`=1, `busy`=0, `done`=0, bit counter 0, shift register 0.
- **IDLE:**
  - `tx_out`=1.
  - On `send`=1, latch `data_in`, `parity_in`, `parity_type` and `stop_bits`.
  - Set `busy`=1 on the next edge and go to ARMED.
- **ARMED:** wait for `baud_tick`. On the tick, go to START.
- **Bit timing:** each bit state holds `tx_out` for exactly one baud period, from one `baud_tick` to the next.
- **START:** `tx_out`=0. On the next tick, go to DATA with counter 0.
- **DATA:**
  - `tx_out`= shift register bit 0, so data goes out LSB first.
  - On each tick, shift right and increment the counter.
  - After DATA_WIDTH bits, go to PARITY if the latched `parity_type` is 01 or 10; otherwise go to STOP.
- **PARITY:** `tx_out`= latched `parity_in`, used as given with no recomputation. On the tick, go to STOP.
- **STOP:**
  - `tx_out`=1 for one period, or for two when `stop_bits`=1.
  - On the final stop tick, go to IDLE. `done` pulses for 1 cycle and `busy` falls in that same cycle.
- **Latched inputs:** all inputs are latched at acceptance. Changes on `data_in`, `parity_in`, `parity_type` or `stop_bits` while `busy`=1 have no effect.
- **Send while busy:** `send` while `busy`=1 is ignored. There is no queueing.
- **Back-to-back frames:** a `send` held high during the `done` cycle is accepted in that cycle because `busy`=0. The next start bit begins at the following tick, giving exactly one extra idle-high baud period.
- **Reset mid-frame:** `rst` during any state abandons the frame. On the next edge `tx_out`=1, `busy`=0, no `done` pulse, state IDLE.
- **Simultaneous events:** `rst` has priority over `send` and `baud_tick`. A `baud_tick` in the acceptance cycle itself does not start the frame; the earliest START is at the next tick.

## Timing

- `tx_out`, `busy` and `done` are registered outputs.
- `busy` is high from the cycle after acceptance.
- `tx_out` changes in the cycle after each `baud_tick` edge that causes a transition.
- Frame length in baud periods is 1 + DATA_WIDTH + P + S, where P is 1 for parity types 01/10 and 0 otherwise, and S is 1 or 2.
- `done` asserts in the cycle after the tick that ends the last stop bit.
- Boundary case: with `baud_tick` tied high, each bit lasts exactly one clock.
  - For 8N1, that gives 10 cycles of frame, plus 1 ARMED cycle at most.

## Structure

- `uart_pkg` holds:
  - parity constants PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE_ALT=2'b11;
  - the state enum;
  - stop-bit constants.
- Single module, no sub-modules. The counter and shift register are inline, sized by DATA_WIDTH with the counter width from $clog2(DATA_WIDTH).
- Baud tick generation and parity generation stay external.

## Test plan

- **Reset:** assert `rst` with random inputs. Required: `tx_out`=1, `busy`=0, `done`=0.
- **Even parity, one stop bit:** `data_in`=8'hA5, `parity_type`=10, `parity_in`=0, `stop_bits`=0.
  - Required `tx_out` per period: 0,1,0,1,0,0,1,0,1,0,1.
  - `done` pulses once after 11 periods.
- **No parity, two stop bits:** `data_in`=8'h3C with `parity_type`=00, then repeated with 11, `stop_bits`=1.
  - Required: 0,0,0,1,1,1,1,0,0,1,1, no parity bit, 11 periods each.
- **Send while busy:** pulse `send` with `data_in`=8'hFF mid-frame. Required: the frame is unchanged and no second frame occurs.
- **Back-to-back:** hold `send` high. Required: the second frame is accepted in the `done` cycle, with exactly one idle-high period between frames.
- **Reset mid-frame:** assert `rst` at DATA bit 3. Required: `tx_out`=1 next cycle, `busy`=0, no `done`; the next `send` of 8'h01 transmits correctly.
